// File: rtl/inst_encode_pkg.sv
// Shared encoding constants for the instruction encoder and its output queue.
package inst_encode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_STORE = 6'd40;

    localparam int FIFO_DEPTH = 4;
    localparam int INST_W     = 32;

    localparam int OPC_LSB = 26;
    localparam int RD_LSB  = 21;
    localparam int RS_LSB  = 16;
    localparam int RT_LSB  = 11;
    localparam int SH_LSB  = 6;
    localparam int FN_LSB  = 0;

    typedef struct packed {
        logic              store;
        logic [INST_W-1:0] inst;
    } fifo_entry_t;

    // True when the 32-bit immediate survives truncation to 16 signed bits.
    function automatic logic imm_fits16(input logic [31:0] imm);
        return imm[31:16] == {16{imm[15]}};
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Small synchronous FIFO with registered storage and occupancy count.
module inst_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_next(rd_ptr);
            // simultaneous push and pop leaves occupancy unchanged
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_encode.sv
// Packs decoded instruction fields back into 32-bit words and queues them
// with a running instruction-memory address for the consumer.
module inst_encode
    import inst_encode_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] ctrl,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  shift,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_store,
    output logic [9:0]  out_addr,
    input  logic        addr_load,
    input  logic [9:0]  addr_base,
    output logic        err_imm,
    input  logic        err_clr,
    output logic [2:0]  count
);

    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [31:0] word;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    fifo_entry_t wr_entry;
    fifo_entry_t head;

    assign opcode = ctrl[11:6];
    assign func   = ctrl[5:0];

    always_comb begin
        word                 = '0;
        word[OPC_LSB +: 6]   = opcode;
        word[RD_LSB +: 5]    = rd;
        word[RS_LSB +: 5]    = rs;
        if (opcode == OP_RTYPE) begin
            word[RT_LSB +: 5] = rt;
            word[SH_LSB +: 5] = shift;
            word[FN_LSB +: 6] = func;
        end else begin
            word[15:0] = imm[15:0];
        end
    end

    assign wr_entry.inst  = word;
    assign wr_entry.store = (opcode == OP_STORE);

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_inst  = head.inst;
    assign out_store = head.store;

    inst_fifo #(
        .WIDTH($bits(fifo_entry_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // address preset beats the pop increment; 10-bit add wraps 1023 -> 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_addr <= '0;
            err_imm  <= 1'b0;
        end else begin
            if (addr_load)
                out_addr <= addr_base;
            else if (pop)
                out_addr <= out_addr + 10'd1;

            if (push && (opcode != OP_RTYPE) && !imm_fits16(imm))
                err_imm <= 1'b1;
            else if (err_clr)
                err_imm <= 1'b0;
        end
    end

endmodule

// File: doc/inst_encode.md
INST_ENCODE -- requirements
Module: inst_encode

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1 bit: field set presented.
REQ-004 SHALL have port in_ready, output, 1 bit: field set can be accepted.
REQ-005 SHALL have port ctrl, input, 12 bits: {opcode[11:6], func[5:0]}, same control encoding the decoder produces.
REQ-006 SHALL have ports rd, rs, rt, shift, input, 5 bits each: register and shift fields.
REQ-007 SHALL have port imm, input, 32 bits: sign-extended immediate.
REQ-008 SHALL have port out_valid, output, 1 bit: encoded word available.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer takes the word.
REQ-010 SHALL have port out_inst, output, 32 bits: encoded instruction word.
REQ-011 SHALL have port out_store, output, 1 bit: head word is a store (opcode 6'd40).
REQ-012 SHALL have port out_addr, output, 10 bits: instruction-memory word address of the head word.
REQ-013 SHALL have ports addr_load, input, 1 bit, and addr_base, input, 10 bits: synchronous address preset.
REQ-014 SHALL have ports err_imm, output, 1 bit, sticky immediate-range error, and err_clr, input, 1 bit, clears it.
REQ-015 SHALL have port count, output, 3 bits: FIFO occupancy 0..4.

Function
REQ-016 SHALL, for opcode 6'd0, encode {opcode, rd, rs, rt, shift, func} into bits [31:26],[25:21],[20:16],[15:11],[10:6],[5:0].
REQ-017 SHALL, for a nonzero opcode, encode {opcode, rd, rs, imm[15:0]}, ignoring func, rt and shift.
REQ-018 SHALL accept a field set when in_valid and in_ready are both high on a rising edge, writing the encoded word and its store flag into a 4-entry FIFO.
REQ-019 SHALL drive in_ready = (count < 4), without combinational dependence on out_ready.
REQ-020 SHALL drive out_valid = (count != 0), with out_inst and out_store taken from the FIFO head.
REQ-021 SHALL give one-cycle minimum latency: a word accepted at edge N is visible at the outputs after edge N.
REQ-022 SHALL hold out_inst, out_store and out_addr stable while out_valid is high and out_ready is low.
REQ-023 SHALL pop on out_valid and out_ready, and SHALL leave count unchanged on a simultaneous push and pop.
REQ-024 SHALL increment out_addr by 1 on each pop, wrapping from 1023 to 0.
REQ-025 SHALL load addr_base on addr_load, which takes priority over a pop increment in the same cycle.
REQ-026 SHALL set err_imm when an I-type word is accepted with imm[31:16] != {16{imm[15]}}, and SHALL still encode the truncated immediate.
REQ-027 SHALL clear err_imm on err_clr; a simultaneous set wins.
REQ-028 SHALL ignore in_valid when full, and SHALL ignore out_ready when empty.

Reset
REQ-029 SHALL, on rst_n low, asynchronously clear count, the FIFO pointers, out_addr, err_imm and the FIFO contents to 0.
REQ-030 SHALL, during and after reset, present out_valid=0, in_ready=1, out_inst=0 and out_store=0.
REQ-031 SHALL discard any in-flight words when reset is asserted mid-operation.

Structure
REQ-032 SHALL take the opcode constants (R-type 6'd0, store 6'd40), the field bit positions and FIFO depth 4 from a shared package.
REQ-033 SHALL place the storage in one sub-module, inst_fifo, parameterised on width and depth; the packing logic stays combinational in inst_encode.

Verification
REQ-034 R-type: ctrl=12'h020, rd=1, rs=2, rt=3, shift=0 -> out_inst=32'h00221820, out_store=0, out_addr=0.
REQ-035 I-type: ctrl=12'h200, rd=4, rs=5, imm=32'hFFFFFFF6 -> out_inst=32'h2085FFF6, err_imm=0.
REQ-036 Store: ctrl=12'hA00, rd=1, rs=2, imm=4 -> out_inst=32'hA0220004, out_store=1; with imm=32'h00010000 -> err_imm=1 until err_clr.
REQ-037 Backpressure: out_ready=0, push 5 words -> count=4, in_ready=0, fifth word not accepted; then out_ready=1 -> 4 words drain in order with addr 0,1,2,3.
REQ-038 Wrap and load: addr_load with addr_base=1023, pop 2 -> out_addr 1023 then 0; addr_load concurrent with a pop -> out_addr=addr_base.
REQ-039 Reset: assert rst_n=0 with 3 words queued -> count=0, out_valid=0, err_imm=0 immediately, without waiting for a clock edge.
